seven_segment_scan_driver: RTL and testbench

Parametrised multi-digit seven-segment display driver for common-anode displays. It accepts a binary value, converts it to BCD with a sequential shift-add-3 (double-dabble) engine, and time-multiplexes the digits onto one shared active-low segment bus with active-low digit enables. It sits between application logic and the board's display pins, replacing per-digit combinational decoding.

---
 rtl/seven_seg_pkg.sv | 51 +++++
 rtl/bin2bcd_seq.sv | 101 ++++++++++
 rtl/seven_segment_scan_driver.sv | 133 +++++++++++++
 tb/tb_seven_segment_scan_driver.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment scan driver:
// segment codes, conversion FSM states and small helper functions.
package seven_seg_pkg;

  // Segment vector abcdefg, bit 6 = a, active-low (0 = segment lit)
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_DIGIT [0:9] = '{
    7'b0000001,  // 0
    7'b1001111,  // 1
    7'b0010010,  // 2
    7'b0000110,  // 3
    7'b1001100,  // 4
    7'b0100100,  // 5
    7'b0100000,  // 6
    7'b0001111,  // 7
    7'b0000000,  // 8
    7'b0000100   // 9
  };

  localparam seg_t SEG_DASH  = 7'b1111110;
  localparam seg_t SEG_BLANK = 7'b1111111;

  // Double-dabble conversion states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_t;

  // Largest value representable on n decimal digits (10^n - 1)
  function automatic int unsigned pow10_minus1(input int unsigned n);
    int unsigned p;
    p = 1;
    for (int unsigned i = 0; i < n; i++) begin
      p = p * 10;
    end
    return p - 1;
  endfunction

  // BCD nibble to segment code; non-decimal nibbles render blank
  function automatic seg_t seg_decode(input logic [3:0] nib);
    seg_t r;
    r = SEG_BLANK;
    if (nib <= 4'd9) begin
      r = SEG_DIGIT[nib];
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3 / double dabble).
// One shift per cycle; a conversion occupies DATA_W+2 cycles from the
// accepting edge to the edge that leaves DONE. busy covers SHIFT and DONE,
// done is high for the single DONE cycle while bcd/overflow are valid.
module bin2bcd_seq
  import seven_seg_pkg::*;
#(
  parameter int DATA_W = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     value,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [63:0] LIMIT = 64'(pow10_minus1(DIGITS));

  bcd_state_t               state_reg, state_next;
  logic [DATA_W-1:0]        bin_reg, bin_next;
  logic [BCD_W-1:0]         bcd_reg, bcd_next;
  logic [CNT_W-1:0]         cnt_reg, cnt_next;
  logic                     ovf_reg, ovf_next;

  logic [BCD_W-1:0]         bcd_adj;
  logic [BCD_W+DATA_W-1:0]  shift_word;

  // Add-3 correction on every nibble that would reach 10 after doubling
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                  (bcd_reg[4*gi +: 4] + 4'd3) :
                                   bcd_reg[4*gi +: 4];
    end
  endgenerate

  assign shift_word = {bcd_adj, bin_reg} << 1;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      bin_reg   <= '0;
      bcd_reg   <= '0;
      cnt_reg   <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      bin_reg   <= bin_next;
      bcd_reg   <= bcd_next;
      cnt_reg   <= cnt_next;
      ovf_reg   <= ovf_next;
    end
  end

  // Next-state and datapath update; counter reaching zero ends SHIFT
  always_comb begin
    state_next = state_reg;
    bin_next   = bin_reg;
    bcd_next   = bcd_reg;
    cnt_next   = cnt_reg;
    ovf_next   = ovf_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = SHIFT;
          bin_next   = value;
          bcd_next   = '0;
          cnt_next   = CNT_W'(DATA_W);
          ovf_next   = (64'(value) > LIMIT);
        end
      end
      SHIFT: begin
        if (cnt_reg == '0) begin
          state_next = DONE;
        end else begin
          {bcd_next, bin_next} = shift_word;
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy     = (state_reg != IDLE);
  assign done     = (state_reg == DONE);
  assign bcd      = bcd_reg;
  assign overflow = ovf_reg;

endmodule

// File: rtl/seven_segment_scan_driver.sv
// Multi-digit common-anode seven-segment driver. A binary value is converted
// to BCD sequentially, latched into a display register on completion, and
// scanned one digit at a time onto a shared active-low segment bus with
// active-low digit enables.
// Optional build macro: SEVEN_SEG_LEADING_BLANK_EN blanks leading zeros
// (digit 0 is always shown).
module seven_segment_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int DATA_W  = 14,
  parameter int CLK_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] value,
  input  logic              load,
  output logic              busy,
  output logic              overflow,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic                  conv_busy;
  logic                  conv_done;
  logic                  conv_ovf;
  logic [4*DIGITS-1:0]   conv_bcd;

  logic [4*DIGITS-1:0]   disp_bcd_reg;
  logic                  ovf_reg;
  logic [DIV_W-1:0]      div_reg;
  logic [IDX_W-1:0]      idx_reg;
  seg_t                  seg_reg, seg_next;
  logic [DIGITS-1:0]     an_reg, an_next;
  logic [3:0]            cur_nib;

  bin2bcd_seq #(
    .DATA_W (DATA_W),
    .DIGITS (DIGITS)
  ) u_conv (
    .clk      (clk),
    .rst      (rst),
    .start    (load),
    .value    (value),
    .busy     (conv_busy),
    .done     (conv_done),
    .bcd      (conv_bcd),
    .overflow (conv_ovf)
  );

  // Display register and overflow flag change only when a conversion completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_bcd_reg <= '0;
      ovf_reg      <= 1'b0;
    end else if (conv_done) begin
      disp_bcd_reg <= conv_bcd;
      ovf_reg      <= conv_ovf;
    end
  end

  // Slot divider and digit index; index advances on divider terminal count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_reg <= '0;
      idx_reg <= '0;
    end else if (div_reg == DIV_W'(CLK_DIV - 1)) begin
      div_reg <= '0;
      if (idx_reg == IDX_W'(DIGITS - 1)) begin
        idx_reg <= '0;
      end else begin
        idx_reg <= idx_reg + IDX_W'(1);
      end
    end else begin
      div_reg <= div_reg + DIV_W'(1);
    end
  end

  assign cur_nib = disp_bcd_reg[4*idx_reg +: 4];

`ifdef SEVEN_SEG_LEADING_BLANK_EN
  logic [DIGITS-1:0] lead_zero;

  // lead_zero[i] is set when digit i and every digit above it are zero
  always_comb begin
    logic seen;
    seen      = 1'b0;
    lead_zero = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (disp_bcd_reg[4*i +: 4] != 4'd0) begin
        seen = 1'b1;
      end
      lead_zero[i] = !seen;
    end
  end
`endif

  // Segment code and enable pattern for the digit currently selected
  always_comb begin
    seg_next = SEG_BLANK;
    an_next  = ~(DIGITS'(1) << idx_reg);
    if (ovf_reg) begin
      seg_next = SEG_DASH;
    end else begin
      seg_next = seg_decode(cur_nib);
`ifdef SEVEN_SEG_LEADING_BLANK_EN
      if ((idx_reg != '0) && lead_zero[idx_reg]) begin
        seg_next = SEG_BLANK;
      end
`endif
    end
  end

  // seg and an are registered together so they always describe one digit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_reg <= SEG_BLANK;
      an_reg  <= '1;
    end else begin
      seg_reg <= seg_next;
      an_reg  <= an_next;
    end
  end

  assign busy     = conv_busy;
  assign overflow = ovf_reg;
  assign seg      = seg_reg;
  assign an       = an_reg;

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// Bench for seven_segment_scan_driver (DIGITS=4, DATA_W=14, CLK_DIV=4).
// A decimal-arithmetic reference model predicts busy, overflow, an and seg
// every cycle; directed and random loads exercise conversion, overflow,
// ignored loads, back-to-back loads and reset during conversion.
module tb_seven_segment_scan_driver;

  localparam int DIGITS  = 4;
  localparam int DATA_W  = 14;
  localparam int CLK_DIV = 4;
  localparam int LIMIT   = 9999;

  localparam logic [6:0] SEG_TBL [10] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
  };

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] value;
  logic              load;
  logic              busy;
  logic              overflow;
  logic [6:0]        seg;
  logic [DIGITS-1:0] an;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // reference model state
  int m_t    = 0;   // edges since reset release
  int m_cnt  = 0;   // remaining busy cycles of the running conversion
  int m_pend = 0;   // value captured by the running conversion
  int m_disp = 0;   // value held by the display register
  bit m_ovf  = 0;   // overflow flag of the display register

  seven_segment_scan_driver #(
    .DIGITS  (DIGITS),
    .DATA_W  (DATA_W),
    .CLK_DIV (CLK_DIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .value    (value),
    .load     (load),
    .busy     (busy),
    .overflow (overflow),
    .seg      (seg),
    .an       (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s t=%0d: observed %0h expected %0h", tag, m_t, obs, exp);
    end
  endtask

  function automatic logic [6:0] exp_seg(input int v, input bit ovf, input int d);
    int p;
    p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    if (ovf) return 7'b1111110;
`ifdef SEVEN_SEG_LEADING_BLANK_EN
    if (d > 0 && v < p) return 7'b1111111;
`endif
    return SEG_TBL[(v / p) % 10];
  endfunction

  task automatic model_reset();
    m_t    = 0;
    m_cnt  = 0;
    m_pend = 0;
    m_disp = 0;
    m_ovf  = 0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovf",  32'(overflow), 32'd0);
    chk("rst_an",   32'(an), 32'hF);
    chk("rst_seg",  32'(seg), 32'h7F);
  endtask

  // one clock edge: advance model, then compare all outputs
  task automatic step();
    int  before_val;
    bit  before_ovf;
    int  dig;
    before_val = m_disp;
    before_ovf = m_ovf;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      m_t++;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_disp = m_pend;
          m_ovf  = (m_pend > LIMIT);
        end
      end else if (load) begin
        m_cnt  = DATA_W + 2;
        m_pend = int'(value);
      end
    end
    #1;
    if (rst) begin
      check_reset_outputs();
    end else begin
      dig = ((m_t - 1) / CLK_DIV) % DIGITS;
      chk("busy", 32'(busy), 32'(m_cnt > 0));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("an", 32'(an), 32'(~(4'b0001 << dig) & 4'hF));
      chk("seg", 32'(seg), 32'(exp_seg(before_val, before_ovf, dig)));
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // single-cycle load pulse, then let the conversion finish and show a full frame
  task automatic do_load(input int v);
    value = DATA_W'(v);
    load  = 1'b1;
    step();
    load  = 1'b0;
    value = DATA_W'($urandom);
    run(DATA_W + 2 + DIGITS * CLK_DIV + 1);
  endtask

  initial begin
    rst   = 1'b1;
    load  = 1'b0;
    value = '0;
    #1;
    check_reset_outputs();
    run(3);
    rst = 1'b0;

    // idle scan: four frames of zeros
    run(4 * DIGITS * CLK_DIV);

    // directed values including boundaries around 10^DIGITS-1
    do_load(1234);
    do_load(12000);
    do_load(7);
    do_load(0);
    do_load(9999);
    do_load(10000);
    do_load(16383);
    do_load(10);

    // random values
    for (int i = 0; i < 6; i++) do_load(int'($urandom_range(0, 16383)));

    // load while busy is ignored
    value = DATA_W'(4321);
    load  = 1'b1;
    step();
    value = DATA_W'(8765);
    run(4);
    load  = 1'b0;
    // wait for conversion end (bounded), then load right after busy falls
    for (int i = 0; i < 40 && m_cnt > 0; i++) step();
    chk("busy_fell", 32'(busy), 32'd0);
    value = DATA_W'(305);
    load  = 1'b1;
    step();
    load  = 1'b0;
    chk("b2b_accept", 32'(busy), 32'd1);
    run(DATA_W + 2 + DIGITS * CLK_DIV + 1);

    // reset asserted mid-conversion
    value = DATA_W'(5678);
    load  = 1'b1;
    step();
    load  = 1'b0;
    run(5);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs();
    model_reset();
    run(2);
    rst = 1'b0;
    run(2 * DIGITS * CLK_DIV);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
